// File: rtl/sccb_config_ctrl_if.sv
// SCCB bus and configuration-table port bundle for sccb_config_ctrl.
// master: the configuration controller. slave: the camera/ROM side (bench or board glue).
interface sccb_config_ctrl_if;
  logic [7:0]  tbl_addr;  // table entry index
  logic [15:0] tbl_data;  // {reg, val}, one cycle after tbl_addr
  logic        sioc;      // SCCB clock, push-pull
  logic        siod_oe;   // 1 = pull SIOD low, 0 = release
  logic        siod_in;   // sampled SIOD pin

  modport master (
    output tbl_addr,
    input  tbl_data,
    output sioc,
    output siod_oe,
    input  siod_in
  );

  modport slave (
    input  tbl_addr,
    output tbl_data,
    input  sioc,
    input  siod_oe,
    output siod_in
  );
endinterface

// File: rtl/sccb_config_ctrl.sv
// OV7670 power-up configuration sequencer over SCCB.
// Walks a synchronous register table of {reg, val} entries, issuing one
// 3-phase SCCB write per entry. 16'hFFF0 inserts a DELAY_CYCLES pause,
// 16'hFFFF ends the table. Entry 255 is always the last entry processed.
// Optional build macro SCCB_READBACK_EN: after each write, set the register
// pointer with a 2-phase write, read the register back and flag a mismatch
// on verify_err.
module sccb_config_ctrl #(
  parameter int         QDIV         = 125,
  parameter int         DELAY_CYCLES = 500000,
  parameter logic [7:0] DEV_ID       = 8'h42
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               start,
  sccb_config_ctrl_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               ack_err,
  output logic [7:0]         entry_cnt
`ifdef SCCB_READBACK_EN
  ,
  output logic               verify_err
`endif
);

  localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES + 1) : 1;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_START  = 4'd3;
  localparam logic [3:0] S_BYTE   = 4'd4;
  localparam logic [3:0] S_STOP   = 4'd5;
  localparam logic [3:0] S_GAP    = 4'd6;
  localparam logic [3:0] S_DELAY  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qidx_q, qidx_d;      // quarter within the current bit/condition
  logic [3:0]    bit_q, bit_d;        // 0..7 data bits, 8 = don't-care bit
  logic [1:0]    phase_q, phase_d;    // byte index within the transaction
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    val_q, val_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          sioc_q, sioc_d;
  logic          siod_oe_q, siod_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic [7:0]    tbl_addr_q, tbl_addr_d;
  logic [7:0]    entry_cnt_q, entry_cnt_d;

  logic          tick;
  logic          advance;
  logic [7:0]    tx_byte;
  logic [1:0]    last_phase;

`ifdef SCCB_READBACK_EN
  localparam logic [1:0] OP_WRITE = 2'd0;  // full register write
  localparam logic [1:0] OP_ADDR  = 2'd1;  // pointer write before read
  localparam logic [1:0] OP_READ  = 2'd2;  // read the register back

  logic [1:0] op_q, op_d;
  logic [7:0] rdata_q, rdata_d;
  logic       verify_err_q, verify_err_d;
  logic       is_read;

  assign is_read    = (op_q == OP_READ);
  assign last_phase = (op_q == OP_WRITE) ? 2'd2 : 2'd1;
  assign verify_err = verify_err_q;
`else
  assign last_phase = 2'd2;
`endif

  assign tick = (qcnt_q == QW'(QDIV - 1));

  assign bus.sioc     = sioc_q;
  assign bus.siod_oe  = siod_oe_q;
  assign bus.tbl_addr = tbl_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ack_err      = ack_err_q;
  assign entry_cnt    = entry_cnt_q;

  // Byte transmitted in the current phase; the read data phase sends all ones
  // so SIOD stays released while the camera drives it.
  always_comb begin
    tx_byte = DEV_ID;
    case (phase_q)
`ifdef SCCB_READBACK_EN
      2'd0:    tx_byte = is_read ? (DEV_ID | 8'h01) : DEV_ID;
      2'd1:    tx_byte = is_read ? 8'hFF : reg_q;
`else
      2'd0:    tx_byte = DEV_ID;
      2'd1:    tx_byte = reg_q;
`endif
      default: tx_byte = val_q;
    endcase
  end

  // Next-state logic: cycle-level table handling, quarter-level bus sequencing.
  always_comb begin
    state_d     = state_q;
    qcnt_d      = tick ? '0 : qcnt_q + 1'b1;
    qidx_d      = qidx_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    reg_d       = reg_q;
    val_d       = val_q;
    dly_d       = dly_q;
    sioc_d      = sioc_q;
    siod_oe_d   = siod_oe_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ack_err_d   = ack_err_q;
    tbl_addr_d  = tbl_addr_q;
    entry_cnt_d = entry_cnt_q;
    advance     = 1'b0;
`ifdef SCCB_READBACK_EN
    op_d         = op_q;
    rdata_d      = rdata_q;
    verify_err_d = verify_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          ack_err_d   = 1'b0;
          tbl_addr_d  = 8'd0;
          entry_cnt_d = 8'd0;  // count restarts with each sequence
`ifdef SCCB_READBACK_EN
          verify_err_d = 1'b0;
`endif
        end
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        qidx_d = 2'd0;
        if (bus.tbl_data == 16'hFFFF) begin
          state_d = S_DONE;
        end else if (bus.tbl_data == 16'hFFF0) begin
          state_d = S_DELAY;
          dly_d   = '0;
        end else begin
          reg_d   = bus.tbl_data[15:8];
          val_d   = bus.tbl_data[7:0];
          state_d = S_START;
`ifdef SCCB_READBACK_EN
          op_d = OP_WRITE;
`endif
        end
      end

      S_START: begin
        if (tick) begin
          if (qidx_q == 2'd0) begin
            sioc_d    = 1'b1;
            siod_oe_d = 1'b0;
            qidx_d    = 2'd1;
          end else begin
            siod_oe_d = 1'b1;  // SIOD falls with SIOC high
            qidx_d    = 2'd0;
            bit_d     = 4'd0;
            phase_d   = 2'd0;
            state_d   = S_BYTE;
          end
        end
      end

      S_BYTE: begin
        if (tick) begin
          qidx_d = qidx_q + 2'd1;
          case (qidx_q)
            2'd0: sioc_d = 1'b0;
            2'd1: siod_oe_d = (bit_q == 4'd8) ? 1'b0 : ~tx_byte[~bit_q[2:0]];
            2'd2: sioc_d = 1'b1;
            default: begin
              if (bit_q != 4'd8) begin
`ifdef SCCB_READBACK_EN
                if (is_read && phase_q == 2'd1) rdata_d = {rdata_q[6:0], bus.siod_in};
`endif
                bit_d = bit_q + 4'd1;
              end else begin
`ifdef SCCB_READBACK_EN
                // Ninth bit of the read byte is our own NA, not the camera's.
                if (is_read && phase_q == 2'd1) begin
                  if (rdata_q != val_q) verify_err_d = 1'b1;
                end else if (bus.siod_in) begin
                  ack_err_d = 1'b1;
                end
`else
                if (bus.siod_in) ack_err_d = 1'b1;
`endif
                bit_d = 4'd0;
                if (phase_q == last_phase) state_d = S_STOP;
                else phase_d = phase_q + 2'd1;
              end
            end
          endcase
        end
      end

      S_STOP: begin
        if (tick) begin
          qidx_d = qidx_q + 2'd1;
          if (qidx_q == 2'd0) begin
            sioc_d    = 1'b0;
            siod_oe_d = 1'b1;
          end else if (qidx_q == 2'd1) begin
            sioc_d = 1'b1;
          end else begin
            siod_oe_d = 1'b0;  // SIOD rises with SIOC high
            qidx_d    = 2'd0;
            state_d   = S_GAP;
`ifdef SCCB_READBACK_EN
            if (op_q == OP_WRITE) entry_cnt_d = entry_cnt_q + 8'd1;
`else
            entry_cnt_d = entry_cnt_q + 8'd1;
`endif
          end
        end
      end

      S_GAP: begin
        if (tick) begin
          qidx_d = qidx_q + 2'd1;
          if (qidx_q == 2'd3) begin
`ifdef SCCB_READBACK_EN
            if (op_q == OP_WRITE) begin
              op_d    = OP_ADDR;
              state_d = S_START;
            end else if (op_q == OP_ADDR) begin
              op_d    = OP_READ;
              state_d = S_START;
            end else begin
              op_d    = OP_WRITE;
              advance = 1'b1;
            end
`else
            advance = 1'b1;
`endif
          end
        end
      end

      S_DELAY: begin
        dly_d = dly_q + 1'b1;
        if (dly_q == DW'(DELAY_CYCLES - 1)) advance = 1'b1;
      end

      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Move to the next table entry; entry 255 never wraps back to 0.
    if (advance) begin
      if (tbl_addr_q == 8'hFF) begin
        state_d = S_DONE;
      end else begin
        tbl_addr_d = tbl_addr_q + 8'd1;
        state_d    = S_FETCH;
      end
    end
  end

  // State registers; reset releases the bus without a stop condition.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      qidx_q      <= 2'd0;
      bit_q       <= 4'd0;
      phase_q     <= 2'd0;
      reg_q       <= 8'd0;
      val_q       <= 8'd0;
      dly_q       <= '0;
      sioc_q      <= 1'b1;
      siod_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      tbl_addr_q  <= 8'd0;
      entry_cnt_q <= 8'd0;
`ifdef SCCB_READBACK_EN
      op_q         <= OP_WRITE;
      rdata_q      <= 8'd0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      qidx_q      <= qidx_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      reg_q       <= reg_d;
      val_q       <= val_d;
      dly_q       <= dly_d;
      sioc_q      <= sioc_d;
      siod_oe_q   <= siod_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      tbl_addr_q  <= tbl_addr_d;
      entry_cnt_q <= entry_cnt_d;
`ifdef SCCB_READBACK_EN
      op_q         <= op_d;
      rdata_q      <= rdata_d;
      verify_err_q <= verify_err_d;
`endif
    end
  end

endmodule

// File: doc/sccb_config_ctrl.md
Name: sccb_config_ctrl

Overview:
- Power-up configuration sequencer for the OV7670 camera over SCCB, the camera's two-wire serial bus.
- Walks an external register table of (reg, value) pairs and issues one SCCB 3-phase write per entry.
- Inserts a programmable delay after table delay markers, for example after the COM7 soft reset.
- Raises done when the table is finished; the pixel capture path is released from reset once done is high.

Parameters:
- QDIV, 125: clk_50 cycles per SIOC quarter-bit. Default gives 100 kHz SIOC.
- DELAY_CYCLES, 500000: wait length for a delay marker. Default is 10 ms.
- DEV_ID, 8'h42: SCCB write address of the camera.

Ports:
- clk_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins the sequence from table entry 0
- tbl_addr  out  8  table entry index
- tbl_data  in  16  {reg[15:8], val[7:0]}; valid exactly one cycle after tbl_addr changes (synchronous ROM)
- sioc  out  1  SCCB clock, push-pull
- siod_oe  out  1  1 = drive SIOD low; 0 = release SIOD (external pull-up)
- siod_in  in  1  sampled SIOD pin
- busy  out  1  sequence in progress
- done  out  1  sticky; table completed
- ack_err  out  1  sticky; a don't-care bit was sampled high
- entry_cnt  out  8  number of writes completed

Behaviour:
- Reset, applied in any state and mid-transaction: sioc=1, siod_oe=0, busy=0, done=0, ack_err=0, tbl_addr=0, entry_cnt=0, FSM=IDLE. The bus is simply released; no stop condition is generated.
- The quarter-tick counter counts 0..QDIV-1 and wraps. All bus actions advance only on the wrap.
- FSM states: IDLE, FETCH, DECODE, START, BYTE, STOP, GAP, DELAY, DONE.
- IDLE:
  - start=1 -> FETCH, with busy=1, done=0, ack_err=0, tbl_addr=0.
  - start is ignored in all other states.
- FETCH: wait 1 cycle for the ROM -> DECODE.
- DECODE:
  - tbl_data=16'hFFFF -> DONE.
  - tbl_data=16'hFFF0 -> DELAY.
  - Otherwise latch reg/val -> START.
- START, 2 quarters:
  - q0: sioc=1, SIOD released.
  - q1: siod_oe=1 (SIOD falls while SIOC is high).
  - Then -> BYTE, phase 0.
- BYTE: 3 phases sent in order: DEV_ID, reg, val. Each phase is 9 bits, MSB first, followed by the don't-care bit. Each bit takes 4 quarters:
  - q0: sioc=0.
  - q1: set siod_oe = ~bit. For the 9th bit, siod_oe=0.
  - q2: sioc=1.
  - q3: for the 9th bit, sample siod_in; a 1 sets ack_err. The transaction is not aborted.
  - After phase 2, bit 9 -> STOP.
- STOP, 3 quarters:
  - sioc=0, siod_oe=1.
  - sioc=1.
  - siod_oe=0 (SIOD rises while SIOC is high).
  - Then entry_cnt++ -> GAP.
- GAP: 4 quarters of bus idle. Then tbl_addr++ -> FETCH.
- DELAY: count DELAY_CYCLES clk_50 cycles with the bus idle. Then tbl_addr++ -> FETCH.
- DONE: busy=0, done=1 -> IDLE. done holds until the next start or reset.
- Wrap-around: if tbl_addr reaches 255 without an end marker, entry 255 is processed and then the FSM goes to DONE. It never wraps to 0.
- Output timing: sioc and siod_oe are registered outputs and change only on quarter-tick boundaries.
- Bit period = 4*QDIV cycles. One write = 2+27*4+3+4 = 117 quarters.

Optional Feature:
- Macro: SCCB_READBACK_EN.
- When defined, after each write's GAP the controller performs:
  - a 2-phase write (DEV_ID, reg) + STOP + GAP;
  - then START, a read phase with ID DEV_ID|1, and 8 bits sampled at q3 with SIOD released;
  - the master then drives NA = 1 (released) and issues STOP.
- Mismatch between the read byte and val sets a sticky output verify_err (1 bit, reset 0). Delay entries are not read back.
- When not defined: no read transaction, no verify_err port, write-only behaviour as above.

Test Plan:
- Table {12 80, FFF0, 11 01, FFFF}, QDIV=2, DELAY_CYCLES=100, start pulse -> 2 writes on the bus with bytes 42/12/80 and 42/11/01. The idle gap between the writes is at least 100 cycles. Then done=1, busy=0, entry_cnt=2.
- Single entry {3A 04, FFFF}, with an SCCB slave model decoding the bus -> start/stop conditions are correct and SIOD never toggles while SIOC=1, except at start/stop. Decoded bytes are 42,3A,04.
- Slave model drives SIOD high on the 2nd don't-care bit -> ack_err=1, the write still completes, done=1.
- Assert reset during BYTE phase 1 -> next cycle sioc=1, siod_oe=0, busy=0. A new start replays from entry 0.
- Pulse start while busy -> ignored; tbl_addr sequence unchanged.
- With SCCB_READBACK_EN, slave model returns 0x05 for a write of 0x04 -> verify_err=1 after entry 0. With a matching slave, verify_err stays 0.
